// File: rtl/nn_fp_pkg.sv
// Shared fp32 types, constants and the combinational
// single-precision multiply used by the trainer datapath.
package nn_fp_pkg;

  typedef logic [31:0] fp32_t;

  localparam fp32_t FP_ZERO    = 32'h0000_0000;
  localparam fp32_t FP_ONE     = 32'h3f80_0000;
  localparam fp32_t FP_QNAN    = 32'h7fc0_0000;
  localparam fp32_t MU_DEFAULT = 32'h3f40_0000;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    DRAIN
  } state_t;

  function automatic int tag_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Round-to-nearest-even; subnormals flush to signed zero
  function automatic fp32_t fp_mul(
    input fp32_t a,
    input fp32_t b
  );
    logic        s;
    logic [7:0]  ea, eb;
    logic [23:0] ma, mb;
    logic [47:0] p;
    logic [22:0] m;
    logic        g, st;
    logic [23:0] mr;
    logic [9:0]  esum;
    logic        a_nan, b_nan;
    logic        a_inf, b_inf;
    logic        a_zero, b_zero;
    s      = a[31] ^ b[31];
    ea     = a[30:23];
    eb     = b[30:23];
    a_nan  = (ea == 8'hff) && (a[22:0] != 23'h0);
    b_nan  = (eb == 8'hff) && (b[22:0] != 23'h0);
    a_inf  = (ea == 8'hff) && (a[22:0] == 23'h0);
    b_inf  = (eb == 8'hff) && (b[22:0] == 23'h0);
    a_zero = (ea == 8'h00);
    b_zero = (eb == 8'h00);
    ma     = {1'b1, a[22:0]};
    mb     = {1'b1, b[22:0]};
    p      = {24'h0, ma} * {24'h0, mb};
    if (p[47]) begin
      m  = p[46:24];
      g  = p[23];
      st = |p[22:0];
    end else begin
      m  = p[45:23];
      g  = p[22];
      st = |p[21:0];
    end
    mr   = {1'b0, m} + {23'h0, g & (st | m[0])};
    esum = {2'b0, ea} + {2'b0, eb}
         + {9'h0, p[47]} + {9'h0, mr[23]};
    if (a_nan || b_nan || (a_inf && b_zero)
        || (b_inf && a_zero))
      return FP_QNAN;
    if (a_inf || b_inf)
      return {s, 8'hff, 23'h0};
    if (a_zero || b_zero || esum <= 10'd127)
      return {s, 31'h0};
    if (esum >= 10'd382)
      return {s, 8'hff, 23'h0};
    esum = esum - 10'd127;
    return {s, esum[7:0], mr[22:0]};
  endfunction

endpackage

// File: rtl/fp_mult_chain.sv
// Two pipelined fp32 multipliers in series computing (a*b)*c,
// with a valid/tag delay line matched to the total latency.
module fp_multiplier
  import nn_fp_pkg::*;
#(
  parameter int MULT_LAT = 5
) (
  input  logic  iCLK,
  input  logic  iRST,
  input  fp32_t iA,
  input  fp32_t iB,
  output fp32_t oP
);

  fp32_t r_pipe [MULT_LAT];

  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      for (int i = 0; i < MULT_LAT; i++)
        r_pipe[i] <= FP_ZERO;
    end else begin
      r_pipe[0] <= fp_mul(iA, iB);
      for (int i = 1; i < MULT_LAT; i++)
        r_pipe[i] <= r_pipe[i-1];
    end
  end

  assign oP = r_pipe[MULT_LAT-1];

endmodule

module fp_mult_chain
  import nn_fp_pkg::*;
#(
  parameter int MULT_LAT = 5,
  parameter int TAG_W    = 2
) (
  input  logic             iCLK,
  input  logic             iRST,
  input  logic             iVALID,
  input  logic [TAG_W-1:0] iTAG,
  input  fp32_t            iA,
  input  fp32_t            iB,
  input  fp32_t            iC,
  output logic             oVALID,
  output logic [TAG_W-1:0] oTAG,
  output fp32_t            oRESULT
);

  localparam int L2 = 2 * MULT_LAT;

  fp32_t            w_p1;
  fp32_t            r_c   [MULT_LAT];
  logic             r_vld [L2];
  logic [TAG_W-1:0] r_tag [L2];

  fp_multiplier #(.MULT_LAT(MULT_LAT)) u_m1 (
    .iCLK (iCLK),
    .iRST (iRST),
    .iA   (iA),
    .iB   (iB),
    .oP   (w_p1)
  );

  // c is delayed so it meets its own product at stage two
  fp_multiplier #(.MULT_LAT(MULT_LAT)) u_m2 (
    .iCLK (iCLK),
    .iRST (iRST),
    .iA   (w_p1),
    .iB   (r_c[MULT_LAT-1]),
    .oP   (oRESULT)
  );

  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      for (int i = 0; i < MULT_LAT; i++)
        r_c[i] <= FP_ZERO;
      for (int i = 0; i < L2; i++) begin
        r_vld[i] <= 1'b0;
        r_tag[i] <= '0;
      end
    end else begin
      r_c[0]   <= iC;
      r_vld[0] <= iVALID;
      r_tag[0] <= iTAG;
      for (int i = 1; i < MULT_LAT; i++)
        r_c[i] <= r_c[i-1];
      for (int i = 1; i < L2; i++) begin
        r_vld[i] <= r_vld[i-1];
        r_tag[i] <= r_tag[i-1];
      end
    end
  end

  assign oVALID = r_vld[L2-1];
  assign oTAG   = r_tag[L2-1];

endmodule

// File: rtl/calculate_delta_vec.sv
// Perceptron weight-update engine: delta[k] = mu * err * x[k],
// one product issued per clock through a shared multiplier chain.
module calculate_delta_vec
  import nn_fp_pkg::*;
#(
  parameter int    NUM_IN   = 3,
  parameter int    MULT_LAT = 5,
  parameter fp32_t MU_RESET = MU_DEFAULT
) (
  input  logic                iCLK,
  input  logic                iRST,
  input  logic                iSTART,
  input  fp32_t               iERROR,
  input  logic [NUM_IN*32-1:0] iX,
  input  logic                iMU_WE,
  input  fp32_t               iMU,
  output logic                oBUSY,
  output logic                oDONE,
  output logic [NUM_IN*32-1:0] oDELTA,
  output fp32_t               oMU
);

  localparam int TAG_W = tag_width(NUM_IN);
  localparam logic [TAG_W-1:0] LAST = TAG_W'(NUM_IN - 1);

  state_t                  r_state, w_next;
  logic [TAG_W-1:0]        r_cnt;
  fp32_t                   r_err, r_mu, r_mu_job;
  logic [NUM_IN-1:0][31:0] r_x, r_delta;
  logic                    r_done;

  logic             w_accept, w_issue, w_fin;
  logic             w_out_vld;
  logic [TAG_W-1:0] w_out_tag;
  fp32_t            w_out;

  assign oBUSY    = (r_state != IDLE);
  assign oDONE    = r_done;
  assign oDELTA   = r_delta;
  assign oMU      = r_mu;
  assign w_accept = iSTART & (~oBUSY | oDONE);
  assign w_issue  = (r_state == ISSUE);
  // Issue is in order, so the last tag leaving means the pipe is empty
  assign w_fin    = (r_state == DRAIN) && w_out_vld
                 && (w_out_tag == LAST);

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:    if (w_accept) w_next = ISSUE;
      ISSUE:   if (r_cnt == LAST) w_next = DRAIN;
      DRAIN:   if (w_fin) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_next;
      r_done  <= w_fin;
      if (w_accept)
        r_cnt <= '0;
      else if (w_issue)
        r_cnt <= r_cnt + 1'b1;
    end
  end

  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      r_err    <= FP_ZERO;
      r_x      <= '0;
      r_mu_job <= MU_RESET;
      r_mu     <= MU_RESET;
    end else begin
      if (w_accept) begin
        r_err    <= iERROR;
        r_x      <= iX;
        r_mu_job <= r_mu;
      end
      if (iMU_WE)
        r_mu <= iMU;
    end
  end

  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST)
      r_delta <= '0;
    else if (w_out_vld)
      r_delta[w_out_tag] <= w_out;
  end

  fp_mult_chain #(
    .MULT_LAT (MULT_LAT),
    .TAG_W    (TAG_W)
  ) u_chain (
    .iCLK    (iCLK),
    .iRST    (iRST),
    .iVALID  (w_issue),
    .iTAG    (r_cnt),
    .iA      (r_err),
    .iB      (r_x[r_cnt]),
    .iC      (r_mu_job),
    .oVALID  (w_out_vld),
    .oTAG    (w_out_tag),
    .oRESULT (w_out)
  );

endmodule

// File: tb/tb_calculate_delta_vec.sv
// Directed bench for calculate_delta_vec (NUM_IN=3, MULT_LAT=5).
module tb_calculate_delta_vec;

  logic        iCLK   = 1'b0;
  logic        iRST   = 1'b1;
  logic        iSTART = 1'b0;
  logic [31:0] iERROR = '0;
  logic [95:0] iX     = '0;
  logic        iMU_WE = 1'b0;
  logic [31:0] iMU    = '0;
  logic        oBUSY;
  logic        oDONE;
  logic [95:0] oDELTA;
  logic [31:0] oMU;

  int checks   = 0;
  int failures = 0;

  calculate_delta_vec #(
    .NUM_IN   (3),
    .MULT_LAT (5),
    .MU_RESET (32'h3f400000)
  ) dut (
    .iCLK   (iCLK),
    .iRST   (iRST),
    .iSTART (iSTART),
    .iERROR (iERROR),
    .iX     (iX),
    .iMU_WE (iMU_WE),
    .iMU    (iMU),
    .oBUSY  (oBUSY),
    .oDONE  (oDONE),
    .oDELTA (oDELTA),
    .oMU    (oMU)
  );

  always #5 iCLK = ~iCLK;

  task automatic issue_start(
    input logic [31:0] e,
    input logic [95:0] x
  );
    @(negedge iCLK);
    iSTART = 1'b1;
    iERROR = e;
    iX     = x;
    @(posedge iCLK);
    #1 iSTART = 1'b0;
  endtask

  task automatic wait_done(output int n);
    n = 0;
    do begin
      @(posedge iCLK);
      #1 n++;
    end while (!oDONE && n < 40);
  endtask

  task automatic test_reset;
    repeat (3) @(posedge iCLK);
    #1;
    checks++;
    if (oBUSY !== 1'b0) begin
      failures++;
      $display("FAIL rst_busy: got %b expected 0", oBUSY);
    end
    checks++;
    if (oDONE !== 1'b0) begin
      failures++;
      $display("FAIL rst_done: got %b expected 0", oDONE);
    end
    checks++;
    if (oDELTA !== 96'h0) begin
      failures++;
      $display("FAIL rst_delta: got %h expected 0", oDELTA);
    end
    checks++;
    if (oMU !== 32'h3f400000) begin
      failures++;
      $display("FAIL rst_mu: got %h expected 3f400000", oMU);
    end
    @(negedge iCLK);
    iRST = 1'b0;
    @(posedge iCLK);
    #1;
    checks++;
    if (oBUSY !== 1'b0) begin
      failures++;
      $display("FAIL rst_idle: got %b expected 0", oBUSY);
    end
  endtask

  task automatic test_default_mu;
    int n;
    logic [95:0] exp;
    exp = {32'h00000000, 32'h3f400000, 32'h3ec00000};
    issue_start(32'h3f000000,
      {32'h00000000, 32'h40000000, 32'h3f800000});
    checks++;
    if (oBUSY !== 1'b1) begin
      failures++;
      $display("FAIL t1_busy: got %b expected 1", oBUSY);
    end
    wait_done(n);
    checks++;
    if (n != 13) begin
      failures++;
      $display("FAIL t1_lat: got %0d expected 13", n);
    end
    checks++;
    if (oDELTA !== exp) begin
      failures++;
      $display("FAIL t1_delta: got %h expected %h", oDELTA, exp);
    end
    checks++;
    if (oBUSY !== 1'b0) begin
      failures++;
      $display("FAIL t1_busy_drop: got %b expected 0", oBUSY);
    end
    @(posedge iCLK);
    #1;
    checks++;
    if (oDONE !== 1'b0) begin
      failures++;
      $display("FAIL t1_pulse: got %b expected 0", oDONE);
    end
  endtask

  task automatic test_mu_load;
    int n;
    logic [95:0] exp;
    exp = {32'h3f000000, 32'hbf800000, 32'hbf000000};
    @(negedge iCLK);
    iMU_WE = 1'b1;
    iMU    = 32'h3f800000;
    @(posedge iCLK);
    #1 iMU_WE = 1'b0;
    checks++;
    if (oMU !== 32'h3f800000) begin
      failures++;
      $display("FAIL t2_mu: got %h expected 3f800000", oMU);
    end
    issue_start(32'hbf000000,
      {32'hbf800000, 32'h40000000, 32'h3f800000});
    wait_done(n);
    checks++;
    if (n != 13) begin
      failures++;
      $display("FAIL t2_lat: got %0d expected 13", n);
    end
    checks++;
    if (oDELTA !== exp) begin
      failures++;
      $display("FAIL t2_delta: got %h expected %h", oDELTA, exp);
    end
  endtask

  task automatic test_start_while_busy;
    int n;
    int pulses;
    int done_at;
    logic [95:0] exp;
    exp = {32'h3f800000, 32'h40800000, 32'h40400000};
    n = 0;
    pulses = 0;
    done_at = -1;
    issue_start(32'h3f800000,
      {32'h3f800000, 32'h40800000, 32'h40400000});
    repeat (25) begin
      @(negedge iCLK);
      iSTART = oBUSY;
      iERROR = $urandom;
      iX     = {$urandom, $urandom, $urandom};
      @(posedge iCLK);
      #1 n++;
      if (oDONE) begin
        pulses++;
        if (done_at < 0) done_at = n;
      end
    end
    iSTART = 1'b0;
    checks++;
    if (pulses != 1) begin
      failures++;
      $display("FAIL t3_pulses: got %0d expected 1", pulses);
    end
    checks++;
    if (done_at != 13) begin
      failures++;
      $display("FAIL t3_lat: got %0d expected 13", done_at);
    end
    checks++;
    if (oBUSY !== 1'b0) begin
      failures++;
      $display("FAIL t3_idle: got %b expected 0", oBUSY);
    end
    checks++;
    if (oDELTA !== exp) begin
      failures++;
      $display("FAIL t3_delta: got %h expected %h", oDELTA, exp);
    end
  endtask

  task automatic test_back_to_back;
    int n;
    logic [95:0] exp_a;
    logic [95:0] exp_b;
    exp_a = {32'h3f800000, 32'h3f000000, 32'h3e800000};
    exp_b = {32'hc0800000, 32'h3f800000, 32'h40000000};
    issue_start(32'h3e800000,
      {32'h40800000, 32'h40000000, 32'h3f800000});
    wait_done(n);
    checks++;
    if (oDELTA !== exp_a) begin
      failures++;
      $display("FAIL t4_delta_a: got %h expected %h",
        oDELTA, exp_a);
    end
    issue_start(32'h40000000,
      {32'hc0000000, 32'h3f000000, 32'h3f800000});
    checks++;
    if (oBUSY !== 1'b1 || oDONE !== 1'b0) begin
      failures++;
      $display("FAIL t4_accept: got busy=%b done=%b expected 1 0",
        oBUSY, oDONE);
    end
    wait_done(n);
    checks++;
    if (n != 13) begin
      failures++;
      $display("FAIL t4_lat: got %0d expected 13", n);
    end
    checks++;
    if (oDELTA !== exp_b) begin
      failures++;
      $display("FAIL t4_delta_b: got %h expected %h",
        oDELTA, exp_b);
    end
  endtask

  task automatic test_mu_same_cycle;
    int n;
    logic [95:0] x;
    logic [95:0] exp_old;
    logic [95:0] exp_new;
    x       = {32'h40800000, 32'h3f800000, 32'h40000000};
    exp_old = {32'h40400000, 32'h3f400000, 32'h3fc00000};
    exp_new = {32'h3f800000, 32'h3e800000, 32'h3f000000};
    @(negedge iCLK);
    iMU_WE = 1'b1;
    iMU    = 32'h3f400000;
    @(posedge iCLK);
    #1 iMU_WE = 1'b0;
    @(negedge iCLK);
    iSTART = 1'b1;
    iERROR = 32'h3f800000;
    iX     = x;
    iMU_WE = 1'b1;
    iMU    = 32'h3e800000;
    @(posedge iCLK);
    #1;
    iSTART = 1'b0;
    iMU_WE = 1'b0;
    checks++;
    if (oMU !== 32'h3e800000) begin
      failures++;
      $display("FAIL t5_mu: got %h expected 3e800000", oMU);
    end
    wait_done(n);
    checks++;
    if (oDELTA !== exp_old) begin
      failures++;
      $display("FAIL t5_old_mu: got %h expected %h",
        oDELTA, exp_old);
    end
    issue_start(32'h3f800000, x);
    wait_done(n);
    checks++;
    if (oDELTA !== exp_new) begin
      failures++;
      $display("FAIL t5_new_mu: got %h expected %h",
        oDELTA, exp_new);
    end
  endtask

  task automatic test_reset_mid_job;
    int n;
    int pulses;
    logic [95:0] exp;
    exp = {32'h40100000, 32'h3fc00000, 32'h3f400000};
    pulses = 0;
    issue_start(32'h40000000,
      {32'h40000000, 32'h40400000, 32'h40800000});
    repeat (5) @(posedge iCLK);
    #1 iRST = 1'b1;
    #1;
    checks++;
    if (oDELTA !== 96'h0 || oBUSY !== 1'b0) begin
      failures++;
      $display("FAIL t6_abort: got delta=%h busy=%b expected 0 0",
        oDELTA, oBUSY);
    end
    checks++;
    if (oMU !== 32'h3f400000) begin
      failures++;
      $display("FAIL t6_mu: got %h expected 3f400000", oMU);
    end
    @(negedge iCLK);
    iRST = 1'b0;
    repeat (20) begin
      @(posedge iCLK);
      #1;
      if (oDONE) pulses++;
    end
    checks++;
    if (pulses != 0 || oDELTA !== 96'h0) begin
      failures++;
      $display("FAIL t6_stale: got pulses=%0d delta=%h expected 0",
        pulses, oDELTA);
    end
    issue_start(32'h3f800000,
      {32'h40400000, 32'h40000000, 32'h3f800000});
    wait_done(n);
    checks++;
    if (n != 13) begin
      failures++;
      $display("FAIL t6_lat: got %0d expected 13", n);
    end
    checks++;
    if (oDELTA !== exp) begin
      failures++;
      $display("FAIL t6_delta: got %h expected %h", oDELTA, exp);
    end
  endtask

  initial begin
    test_reset();
    test_default_mu();
    test_mu_load();
    test_start_while_busy();
    test_back_to_back();
    test_mu_same_cycle();
    test_reset_mid_job();
    $display("TB_RESULT checks=%0d failures=%0d",
      checks, failures);
    $finish;
  end

endmodule
